// File: rtl/audio_pkg.sv
// Shared audio-path definitions: I2S frame defaults and the transmit/receive run-state enum.
package audio_pkg;
  localparam int DIV_CLK_DEF   = 28;
  localparam int SAMPLE_W_DEF  = 24;
  localparam int SLOT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } run_state_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock and frame position generator; counters sit at zero while run is low.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int DIV_CLK   = DIV_CLK_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  localparam int CNT_W    = $clog2(DIV_CLK),
  localparam int BIT_W    = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             sck_i,
  output logic             ws_i,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             shift_tick,
  output logic             frame_end
);
  logic [CNT_W-1:0] sck_cnt;
  logic             sck_last;
  logic             bit_last;

  assign sck_last   = (sck_cnt == CNT_W'(DIV_CLK - 1));
  assign bit_last   = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1));
  assign sck_i      = (sck_cnt >= CNT_W'(DIV_CLK / 2));
  assign ws_i       = (bit_cnt >= BIT_W'(SLOT_BITS));
  // Last clk of an SCK period, so a shifted MSB appears exactly at the falling edge.
  assign shift_tick = run & sck_last;
  assign frame_end  = shift_tick & bit_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_cnt <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      sck_cnt <= '0;
      bit_cnt <= '0;
    end else if (sck_last) begin
      sck_cnt <= '0;
      bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
    end else begin
      sck_cnt <= sck_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-deep holding register feeding per-channel shift registers,
// with run/drain control and registered SCK/WS/SD that share a common one-clk lag.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int DIV_CLK   = DIV_CLK_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  localparam int BIT_W    = $clog2(2 * SLOT_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_ldata,
  input  logic [SAMPLE_W-1:0] in_rdata,
  output logic                dac_sck,
  output logic                dac_ws,
  output logic                dac_sd,
  output logic                frame_st,
  output logic                underrun
);
  run_state_t          state;
  logic                run;
  logic                sck_i, ws_i, sd_i;
  logic [BIT_W-1:0]    bit_cnt;
  logic                shift_tick, frame_end;
  logic                hold_full, accept, load;
  logic                in_left, in_right;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] sh_l, sh_r;

  assign run = (state != ST_IDLE);

  i2s_clk_gen #(
    .DIV_CLK  (DIV_CLK),
    .SLOT_BITS(SLOT_BITS)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .sck_i     (sck_i),
    .ws_i      (ws_i),
    .bit_cnt   (bit_cnt),
    .shift_tick(shift_tick),
    .frame_end (frame_end)
  );

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;
  // A frame boundary loads the shifters, except the one that ends a drain.
  assign load     = ((state == ST_IDLE) & en) |
                    (frame_end & ((state == ST_RUN) | en));

  assign in_left  = (bit_cnt >= BIT_W'(1)) && (bit_cnt <= BIT_W'(SAMPLE_W));
  assign in_right = (bit_cnt >= BIT_W'(SLOT_BITS + 1)) &&
                    (bit_cnt <= BIT_W'(SLOT_BITS + SAMPLE_W));
  assign sd_i     = in_left  ? sh_l[SAMPLE_W-1] :
                    in_right ? sh_r[SAMPLE_W-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= in_ldata;
      hold_r <= in_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      sh_l      <= '0;
      sh_r      <= '0;
      dac_sck   <= 1'b0;
      dac_ws    <= 1'b0;
      dac_sd    <= 1'b0;
      frame_st  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      dac_sck  <= sck_i;
      dac_ws   <= ws_i;
      dac_sd   <= sd_i;
      frame_st <= load;
      underrun <= load & ~hold_full;

      if (load)        hold_full <= accept;
      else if (accept) hold_full <= 1'b1;

      if (load) begin
        sh_l <= hold_full ? hold_l : '0;
        sh_r <= hold_full ? hold_r : '0;
      end else if (shift_tick) begin
        if (in_left)  sh_l <= {sh_l[SAMPLE_W-2:0], 1'b0};
        if (in_right) sh_r <= {sh_r[SAMPLE_W-2:0], 1'b0};
      end

      unique case (state)
        ST_IDLE:  if (en) state <= ST_RUN;
        ST_RUN:   if (!en) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (en)             state <= ST_RUN;
          else if (frame_end) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: accepted pairs are queued and checked against the
// SD/WS bit stream captured on dac_sck rising edges for each frame.
module tb_i2s_dac_tx;
  localparam int DIV   = 8;
  localparam int SW    = 24;
  localparam int SB    = 32;
  localparam int FRAME = DIV * 2 * SB;
  localparam logic [63:0] WS_PAT = 64'hFFFF_FFFF_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_ldata = '0;
  logic [SW-1:0] in_rdata = '0;
  logic          in_ready, dac_sck, dac_ws, dac_sd, frame_st, underrun;

  i2s_dac_tx #(.DIV_CLK(DIV), .SAMPLE_W(SW), .SLOT_BITS(SB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ldata(in_ldata),
    .in_rdata(in_rdata),
    .dac_sck (dac_sck),
    .dac_ws  (dac_ws),
    .dac_sd  (dac_sd),
    .frame_st(frame_st),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [2*SW-1:0] pair);
    logic [63:0] f;
    logic [SW-1:0] l, r;
    f = '0;
    l = pair[2*SW-1:SW];
    r = pair[SW-1:0];
    for (int k = 0; k < SW; k++) begin
      f[1 + k]      = l[SW-1-k];
      f[SB + 1 + k] = r[SW-1-k];
    end
    return f;
  endfunction

  // Scoreboard and frame monitor
  logic [2*SW-1:0] exp_q[$];
  longint          acc_q[$];
  longint          cyc = 0;
  bit              in_frame = 1'b0;
  int              idx = 0;
  logic            prev_sck = 1'b0;
  logic            exp_ur;
  logic [63:0]     got_sd, got_ws, exp_frame;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      idx      = 0;
      prev_sck = 1'b0;
      exp_q.delete();
      acc_q.delete();
    end else begin
      cyc++;
      if (dac_sck && !prev_sck && in_frame) begin
        got_sd[idx] = dac_sd;
        got_ws[idx] = dac_ws;
        idx++;
        if (idx == 64) begin
          check("frame_sd", got_sd, exp_frame);
          check("frame_ws", got_ws, WS_PAT);
          in_frame = 1'b0;
        end
      end
      prev_sck = dac_sck;
      if (frame_st) begin
        if (in_frame) check("frame_cut", 64'(idx), 64'(64));
        // A pair taken in the boundary clk itself waits for the following frame.
        if (acc_q.size() > 0 && acc_q[0] <= cyc - 2) begin
          exp_frame = frame_bits(exp_q.pop_front());
          void'(acc_q.pop_front());
          exp_ur = 1'b0;
        end else begin
          exp_frame = '0;
          exp_ur    = 1'b1;
        end
        check("underrun", 64'(underrun), 64'(exp_ur));
        in_frame = 1'b1;
        idx      = 0;
      end else if (underrun) begin
        check("underrun_lone", 64'(underrun), 64'(0));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_ldata, in_rdata});
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ldata = l;
    in_rdata = r;
    while (!in_ready && t < 3 * FRAME) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3 * FRAME) check("push_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_st();
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!frame_st && t < 2 * FRAME);
    if (!frame_st) check("frame_st_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int quiet;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck",   64'(dac_sck),  64'(0));
    check("rst_ws",    64'(dac_ws),   64'(0));
    check("rst_sd",    64'(dac_sd),   64'(0));
    check("rst_fst",   64'(frame_st), 64'(0));
    check("rst_ur",    64'(underrun), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // Start with nothing held: first frame is silent, then one pair plays next frame.
    @(posedge clk); #1;
    en = 1'b1;
    wait_frame_st();
    repeat (5 * DIV) @(posedge clk);
    push_pair(24'hA5F00F, 24'h123456);
    check("ready_after_push", 64'(in_ready), 64'(0));
    wait_frame_st();
    wait_frame_st();
    wait_frame_st();

    // Back-to-back pairs: the second stalls until the next boundary.
    repeat (3 * DIV) @(posedge clk);
    push_pair(24'h800000, 24'h7FFFFF);
    check("ready_b2b", 64'(in_ready), 64'(0));
    push_pair(24'hFFFFFF, 24'h000001);
    push_pair(SW'($urandom), SW'($urandom));
    push_pair(SW'($urandom), SW'($urandom));
    wait_frame_st();
    wait_frame_st();

    // Drain: drop en around bit 10, hold a pair across the idle gap, restart.
    wait_frame_st();
    repeat (10 * DIV) @(posedge clk);
    #1;
    en = 1'b0;
    push_pair(24'h5A5A5A, 24'hC3C3C3);
    repeat (58 * DIV) @(posedge clk);
    quiet = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (dac_sck || dac_ws || dac_sd || frame_st) quiet++;
    end
    check("idle_quiet", 64'(quiet), 64'(0));
    check("idle_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    check("restart_fst", 64'(frame_st), 64'(1));
    wait_frame_st();
    wait_frame_st();
    check("queue_left", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset in the right slot with a pair pending.
    repeat (2 * DIV) @(posedge clk);
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    repeat (37 * DIV + DIV / 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sck",   64'(dac_sck),  64'(0));
    check("arst_ws",    64'(dac_ws),   64'(0));
    check("arst_sd",    64'(dac_sd),   64'(0));
    check("arst_fst",   64'(frame_st), 64'(0));
    check("arst_ur",    64'(underrun), 64'(0));
    check("arst_ready", 64'(in_ready), 64'(1));
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
